// File: rtl/minhash_jaccard_engine.sv
// MinHash Jaccard estimator: per round, hash every k-mer of both sequences, keep each minimum, count rounds with equal minima.
// Optional MINHASH_PRIME_MOD_EN selects h(x) = (a*x + b) mod (2^31-1); default build truncates to KMER_W bits.
module minhash_jaccard_engine #(
   parameter int KMER_W    = 32,
   parameter int NUM_KMERS = 49,
   parameter int NUM_HASH  = 8,
   parameter int SIM_W     = $clog2(NUM_HASH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   input  logic [NUM_KMERS*KMER_W-1:0] kmersSeqOne,
   input  logic [NUM_KMERS*KMER_W-1:0] kmersSeqTwo,
   input  logic [KMER_W-1:0]           randA,
   input  logic [KMER_W-1:0]           randB,
   input  logic                        coefValid,
   output logic                        coefReady,
   output logic                        done,
   output logic [SIM_W-1:0]            jaccardSimilarity
);

   localparam int KI_W = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1;
   localparam int HI_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
   localparam logic [KI_W-1:0] KMER_LAST = KI_W'(NUM_KMERS - 1);
   localparam logic [HI_W-1:0] HASH_LAST = HI_W'(NUM_HASH - 1);

   typedef enum logic [2:0] {IDLE, WAIT_COEF, SCAN, COMPARE, DONE} state_t;

   state_t                              state_q, state_d;
   logic [NUM_KMERS-1:0][KMER_W-1:0]    seq_one_q, seq_one_d;
   logic [NUM_KMERS-1:0][KMER_W-1:0]    seq_two_q, seq_two_d;
   logic [KMER_W-1:0]                   rand_a_q, rand_a_d;
   logic [KMER_W-1:0]                   rand_b_q, rand_b_d;
   logic [KMER_W-1:0]                   min_one_q, min_one_d;
   logic [KMER_W-1:0]                   min_two_q, min_two_d;
   logic [KI_W-1:0]                     kmer_idx_q, kmer_idx_d;
   logic [HI_W-1:0]                     hash_idx_q, hash_idx_d;
   logic [SIM_W-1:0]                    match_cnt_q, match_cnt_d;
   logic [SIM_W-1:0]                    sim_q, sim_d;
   logic [SIM_W-1:0]                    match_next;
   logic [KMER_W-1:0]                   cur_one, cur_two;
   logic [KMER_W-1:0]                   h_one, h_two;
   logic [KMER_W-1:0]                   min_init;

   assign cur_one = seq_one_q[kmer_idx_q];
   assign cur_two = seq_two_q[kmer_idx_q];

`ifdef MINHASH_PRIME_MOD_EN
   localparam logic [2*KMER_W:0] PRIME = (2*KMER_W+1)'(64'h7FFF_FFFF);
   logic [2*KMER_W:0] full_one, full_two;

   always_comb begin
      full_one = (2*KMER_W+1)'(rand_a_q) * (2*KMER_W+1)'(cur_one) + (2*KMER_W+1)'(rand_b_q);
      full_two = (2*KMER_W+1)'(rand_a_q) * (2*KMER_W+1)'(cur_two) + (2*KMER_W+1)'(rand_b_q);
      h_one    = KMER_W'(full_one % PRIME);
      h_two    = KMER_W'(full_two % PRIME);
      min_init = KMER_W'(64'h7FFF_FFFE);
   end
`else
   always_comb begin
      h_one    = rand_a_q * cur_one + rand_b_q;
      h_two    = rand_a_q * cur_two + rand_b_q;
      min_init = '1;
   end
`endif

   assign match_next = match_cnt_q + SIM_W'(min_one_q == min_two_q);

   always_comb begin
      state_d     = state_q;
      seq_one_d   = seq_one_q;
      seq_two_d   = seq_two_q;
      rand_a_d    = rand_a_q;
      rand_b_d    = rand_b_q;
      min_one_d   = min_one_q;
      min_two_d   = min_two_q;
      kmer_idx_d  = kmer_idx_q;
      hash_idx_d  = hash_idx_q;
      match_cnt_d = match_cnt_q;
      sim_d       = sim_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               seq_one_d   = kmersSeqOne;
               seq_two_d   = kmersSeqTwo;
               match_cnt_d = '0;
               hash_idx_d  = '0;
               state_d     = WAIT_COEF;
            end
         end
         WAIT_COEF: begin
            if (coefValid) begin
               rand_a_d   = randA;
               rand_b_d   = randB;
               min_one_d  = min_init;
               min_two_d  = min_init;
               kmer_idx_d = '0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            if (h_one < min_one_q) min_one_d = h_one;
            if (h_two < min_two_q) min_two_d = h_two;
            if (kmer_idx_q == KMER_LAST) state_d = COMPARE;
            else kmer_idx_d = kmer_idx_q + 1'b1;
         end
         COMPARE: begin
            match_cnt_d = match_next;
            if (hash_idx_q == HASH_LAST) begin
               // result register loads on entry to DONE so it is valid alongside the done pulse
               sim_d   = match_next;
               state_d = DONE;
            end else begin
               hash_idx_d = hash_idx_q + 1'b1;
               state_d    = WAIT_COEF;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         seq_one_q   <= '0;
         seq_two_q   <= '0;
         rand_a_q    <= '0;
         rand_b_q    <= '0;
         min_one_q   <= '0;
         min_two_q   <= '0;
         kmer_idx_q  <= '0;
         hash_idx_q  <= '0;
         match_cnt_q <= '0;
         sim_q       <= '0;
      end else begin
         state_q     <= state_d;
         seq_one_q   <= seq_one_d;
         seq_two_q   <= seq_two_d;
         rand_a_q    <= rand_a_d;
         rand_b_q    <= rand_b_d;
         min_one_q   <= min_one_d;
         min_two_q   <= min_two_d;
         kmer_idx_q  <= kmer_idx_d;
         hash_idx_q  <= hash_idx_d;
         match_cnt_q <= match_cnt_d;
         sim_q       <= sim_d;
      end
   end

   assign busy              = (state_q != IDLE);
   assign coefReady         = (state_q == WAIT_COEF);
   assign done              = (state_q == DONE);
   assign jaccardSimilarity = sim_q;

endmodule

// File: tb/tb_minhash_jaccard_engine.sv
// Directed bench for minhash_jaccard_engine at default parameters; expected values are hand-derived per scenario.
module tb_minhash_jaccard_engine;

   localparam int KMER_W    = 32;
   localparam int NUM_KMERS = 49;
   localparam int NUM_HASH  = 8;
   localparam int SIM_W     = $clog2(NUM_HASH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, coefReady, done;
   logic [NUM_KMERS-1:0][KMER_W-1:0] seq1 = '0;
   logic [NUM_KMERS-1:0][KMER_W-1:0] seq2 = '0;
   logic [KMER_W-1:0] randA = '0;
   logic [KMER_W-1:0] randB = '0;
   logic coefValid = 1'b0;
   logic [SIM_W-1:0] jaccardSimilarity;

   logic [KMER_W-1:0] ta [NUM_HASH];
   logic [KMER_W-1:0] tb [NUM_HASH];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   minhash_jaccard_engine #(
      .KMER_W(KMER_W), .NUM_KMERS(NUM_KMERS), .NUM_HASH(NUM_HASH), .SIM_W(SIM_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .kmersSeqOne(seq1), .kmersSeqTwo(seq2),
      .randA(randA), .randB(randB), .coefValid(coefValid), .coefReady(coefReady),
      .done(done), .jaccardSimilarity(jaccardSimilarity)
   );

   // Drives one comparison from a negedge-aligned loop; cycle 1 is the cycle after start is sampled.
   task automatic run_cmp(input int stall_round, input bit pulse_start, input bit scramble,
                          output int lat, output int ndone, output int rdy_total,
                          output int rdy_stall, output logic [SIM_W-1:0] res);
      int cyc, round, stall_left;
      lat = -1; ndone = 0; rdy_total = 0; rdy_stall = 0; res = '0;
      round = 0; stall_left = 3;
      @(negedge clk);
      start = 1'b1; coefValid = 1'b1; randA = ta[0]; randB = tb[0];
      @(negedge clk);
      start = 1'b0; cyc = 1;
      while (cyc < 1000 && !(lat > 0 && cyc > lat + 5)) begin
         if (done) begin
            ndone++;
            if (lat < 0) begin lat = cyc; res = jaccardSimilarity; end
         end
         if (scramble && cyc == 3) seq1 = ~seq1;
         if (pulse_start) start = (cyc == 100 || cyc == 300);
         if (round < NUM_HASH) begin randA = ta[round]; randB = tb[round]; end
         if (coefReady) rdy_total++;
         if (coefReady && round == stall_round) rdy_stall++;
         if (coefReady && round == stall_round && stall_left > 0) begin
            coefValid = 1'b0; stall_left--;
         end else coefValid = 1'b1;
         if (coefReady && coefValid) round++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; coefValid = 1'b0;
   endtask

   task automatic set_identical();
      for (int i = 0; i < NUM_KMERS; i++) begin
         seq1[i] = i * 32'h9E37_79B1 + 32'h1234;
         seq2[i] = i * 32'h9E37_79B1 + 32'h1234;
      end
      ta = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h3, 32'h7FFF_FFFF,
             32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0001_0001, 32'hCAFE_BABE};
      tb = '{32'h0, 32'h1111, 32'hFFFF_FFF0, 32'h42,
             32'h8000_0000, 32'h5, 32'hABCD_0123, 32'h9};
   endtask

   task automatic set_mixed();
      for (int i = 0; i < NUM_KMERS; i++) begin
         seq1[i] = i + 10;
         seq2[i] = i + 10;
      end
      seq2[0] = 100;
      // a=1,b=0 rounds see minima 10 vs 11; a=0 rounds see constant b on both sides
      ta = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
      tb = '{32'd0, 32'd7, 32'd0, 32'd3, 32'd9, 32'd0, 32'd1, 32'd0};
   endtask

   task automatic test_reset();
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (coefReady !== 1'b0) begin errors++; $display("FAIL reset_coefReady: got %b want 0", coefReady); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (jaccardSimilarity !== '0) begin errors++; $display("FAIL reset_sim: got %0d want 0", jaccardSimilarity); end
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_priority: busy %b want 0", busy); end
   endtask

   task automatic test_identical();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      set_identical();
      run_cmp(-1, 1'b0, 1'b1, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL identical_sim: got %0d want 8", res); end
      checks++; if (lat !== 409) begin errors++; $display("FAIL identical_latency: got %0d want 409", lat); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL identical_done_count: got %0d want 1", nd); end
      checks++; if (rt !== 8) begin errors++; $display("FAIL identical_coefReady_cycles: got %0d want 8", rt); end
      checks++; if (jaccardSimilarity !== 4'd8) begin errors++; $display("FAIL identical_sim_hold: got %0d want 8", jaccardSimilarity); end
   endtask

   task automatic test_disjoint();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      for (int i = 0; i < NUM_KMERS; i++) begin seq1[i] = 32'h0; seq2[i] = 32'h1; end
      for (int r = 0; r < NUM_HASH; r++) begin ta[r] = 32'd1; tb[r] = 32'd0; end
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd0) begin errors++; $display("FAIL disjoint_sim: got %0d want 0", res); end
      checks++; if (lat !== 409) begin errors++; $display("FAIL disjoint_latency: got %0d want 409", lat); end
   endtask

   task automatic test_const_hash();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      for (int i = 0; i < NUM_KMERS; i++) begin seq1[i] = i * 3; seq2[i] = i * 7 + 1; end
      for (int r = 0; r < NUM_HASH; r++) begin ta[r] = 32'd0; tb[r] = 32'd5; end
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL const_hash_sim: got %0d want 8", res); end
   endtask

   task automatic test_mixed();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      set_mixed();
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd4) begin errors++; $display("FAIL mixed_sim: got %0d want 4", res); end
   endtask

   task automatic test_truncation();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      // 2*0x80000001 wraps to 2, equal to 2*1
      for (int i = 0; i < NUM_KMERS; i++) begin seq1[i] = 32'h8000_0001; seq2[i] = 32'h1; end
      for (int r = 0; r < NUM_HASH; r++) begin ta[r] = 32'd2; tb[r] = 32'd0; end
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL truncation_sim: got %0d want 8", res); end
   endtask

   task automatic test_stall();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      set_identical();
      run_cmp(2, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL stall_sim: got %0d want 8", res); end
      checks++; if (lat !== 412) begin errors++; $display("FAIL stall_latency: got %0d want 412", lat); end
      checks++; if (rs !== 4) begin errors++; $display("FAIL stall_coefReady_hold: got %0d want 4", rs); end
      checks++; if (rt !== 11) begin errors++; $display("FAIL stall_coefReady_cycles: got %0d want 11", rt); end
   endtask

   task automatic test_start_while_busy();
      int lat, nd, rt, rs; logic [SIM_W-1:0] res;
      set_mixed();
      run_cmp(-1, 1'b1, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd4) begin errors++; $display("FAIL busy_start_sim: got %0d want 4", res); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", nd); end
      checks++; if (lat !== 409) begin errors++; $display("FAIL busy_start_latency: got %0d want 409", lat); end
   endtask

   task automatic test_reset_mid();
      int lat, nd, rt, rs, seen; logic [SIM_W-1:0] res;
      set_identical();
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      @(negedge clk);
      start = 1'b1; coefValid = 1'b1; randA = 32'h3; randB = 32'h7;
      @(negedge clk);
      start = 1'b0;
      // cycle 70 lies in round 2 SCAN (cycles 53..101)
      repeat (69) @(negedge clk);
      checks++; if (busy !== 1'b1 || coefReady !== 1'b0) begin
         errors++; $display("FAIL mid_scan_state: busy %b coefReady %b want 1 0", busy, coefReady); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      checks++; if (jaccardSimilarity !== '0) begin errors++; $display("FAIL mid_reset_sim: got %0d want 0", jaccardSimilarity); end
      seen = 0;
      repeat (450) begin @(negedge clk); if (done) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", seen); end
      coefValid = 1'b0;
      run_cmp(-1, 1'b0, 1'b0, lat, nd, rt, rs, res);
      checks++; if (res !== 4'd8) begin errors++; $display("FAIL after_reset_sim: got %0d want 8", res); end
      checks++; if (lat !== 409) begin errors++; $display("FAIL after_reset_latency: got %0d want 409", lat); end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_disjoint();
      test_const_hash();
      test_mixed();
      test_truncation();
      test_stall();
      test_start_while_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/minhash_jaccard_engine.md
MINHASH_JACCARD_ENGINE -- requirements
Module: minhash_jaccard_engine

Interface
REQ-001 SHALL have parameter KMER_W, default 32: bits per k-mer word and per hash coefficient.
REQ-002 SHALL have parameter NUM_KMERS, default 49: k-mers per sequence.
REQ-003 SHALL have parameter NUM_HASH, default 8: hash functions (rounds) per comparison.
REQ-004 SHALL have parameter SIM_W, default $clog2(NUM_HASH+1): similarity count width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: request a new comparison.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port kmersSeqOne, input, NUM_KMERS*KMER_W bits: packed k-mers of sequence one, index 0 in the LSBs.
REQ-010 SHALL have port kmersSeqTwo, input, NUM_KMERS*KMER_W bits: packed k-mers of sequence two, index 0 in the LSBs.
REQ-011 SHALL have port randA, input, KMER_W bits: hash multiplier for the current round.
REQ-012 SHALL have port randB, input, KMER_W bits: hash addend for the current round.
REQ-013 SHALL have port coefValid, input, 1 bit: randA/randB valid.
REQ-014 SHALL have port coefReady, output, 1 bit: engine accepts coefficients.
REQ-015 SHALL have port done, output, 1 bit: one-cycle result pulse.
REQ-016 SHALL have port jaccardSimilarity, output, SIM_W bits: count of rounds whose minima matched.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_COEF, SCAN, COMPARE and DONE.
REQ-018 IDLE, start=1: SHALL latch both k-mer buses, clear matchCnt and hashIdx, and go to WAIT_COEF; start SHALL be ignored in every other state.
REQ-019 WAIT_COEF: coefReady SHALL be 1 (0 in all other states); on coefValid&coefReady, SHALL latch randA/randB, set minOne=minTwo=all-ones, set kmerIdx=0, and go to SCAN; without coefValid it SHALL stall indefinitely.
REQ-020 SCAN, one cycle per k-mer index: SHALL compute hOne=h(kmersSeqOne[kmerIdx]) and hTwo=h(kmersSeqTwo[kmerIdx]) and replace each minimum only when strictly less (a tie keeps the old value); at kmerIdx=NUM_KMERS-1 SHALL go to COMPARE.
REQ-021 COMPARE: SHALL increment matchCnt when minOne==minTwo; at hashIdx=NUM_HASH-1 SHALL go to DONE, otherwise SHALL increment hashIdx and go to WAIT_COEF.
REQ-022 DONE: SHALL load jaccardSimilarity with matchCnt, assert done for exactly one cycle, and return to IDLE.
REQ-023 Default hash: h(x) = (randA*x + randB) mod 2^KMER_W, i.e. product and sum truncated to KMER_W bits.
REQ-024 With coefValid held high, done SHALL assert exactly NUM_HASH*(NUM_KMERS+2)+1 cycles after the cycle in which start is sampled (409 at the defaults).
REQ-025 jaccardSimilarity SHALL hold its value until the next DONE; matchCnt SHALL never exceed NUM_HASH.
REQ-026 Changes to the k-mer buses after start is sampled SHALL have no effect on the running comparison.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE and set busy=0, coefReady=0, done=0, jaccardSimilarity=0, matchCnt=0, hashIdx=0 and kmerIdx=0.
REQ-028 rst asserted mid-operation SHALL abort the comparison with no done pulse; rst SHALL take priority over start.

Configuration
REQ-029 Macro MINHASH_PRIME_MOD_EN defined: h(x) SHALL be (randA*x + randB) mod (2^31-1), evaluated at full 2*KMER_W+1 bit precision, with minima initialised to 2^31-2.
REQ-030 MINHASH_PRIME_MOD_EN undefined: the REQ-023 truncating hash SHALL apply and no modulo logic SHALL be synthesised.

Verification
REQ-031 Defaults, identical buses, 8 arbitrary coefficient pairs with coefValid held high -> jaccardSimilarity=8 and done exactly 409 cycles after start.
REQ-032 Seq one all 0x00000000, seq two all 0x00000001, a=1 and b=0 every round -> jaccardSimilarity=0.
REQ-033 a=0, b=5 every round, arbitrary differing buses -> jaccardSimilarity=8.
REQ-034 coefValid low for 3 cycles before round 3 -> coefReady stays high, FSM holds in WAIT_COEF, done is delayed by 3 cycles, and the result is unchanged.
REQ-035 rst pulsed during round 2 SCAN -> busy=0 and jaccardSimilarity=0 next cycle, no done pulse; a following start completes normally.
REQ-036 start pulsed while busy -> ignored, a single done pulse, and the result equals the undisturbed run.
